ifetch_prefetch: RTL

Instruction fetch stage with a small prefetch queue, sitting directly upstream of the fetch/decode stage of the 10-bit pipelined CPU. It drives the synchronous instruction ROM (one-cycle read latency), buffers returned words with their PCs, and presents them to decode over a valid/ready handshake. It also handles branch/jump redirects by flushing the queue, and handles CPU halt by stopping issue.

---
 rtl/ifetch_prefetch_if.sv | 58 +++++
 rtl/ifetch_prefetch.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch_if.sv
// ifetch_prefetch_if
//   Bundles the fetch stage's ROM port, decode-side handshake and control
//   inputs so that the fetch unit and its environment share one port list.
//
//   Signals
//     imem_req / imem_addr   ROM read strobe and address (fetch unit -> ROM)
//     imem_rdata             ROM word for the previous cycle's request
//     out_valid / out_ready  queue-head handshake to decode; an entry moves
//                            on a cycle where both are high at the rising
//                            edge. out_valid does not depend on out_ready.
//     out_instr / out_pc     queue-head payload, meaningful while out_valid
//     redirect / redirect_pc branch/jump pulse and its new fetch address
//     halt / halted          halt request in, registered halted status out
//     q_count                occupied queue entries
//     dbg_state              fetch FSM state (0 FETCH, 1 FULL, 2 HALTED)
//
//   Modports
//     master  the fetch unit
//     slave   the surrounding CPU / ROM / testbench
interface ifetch_prefetch_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 10,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic [INSTR_W-1:0] out_instr;
    logic [PC_W-1:0]    out_pc;
    logic               out_ready;
    logic               redirect;
    logic [PC_W-1:0]    redirect_pc;
    logic               halt;
    logic               halted;
    logic [CNT_W-1:0]   q_count;
    logic [1:0]         dbg_state;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata,
        output out_valid, out_instr, out_pc,
        input  out_ready,
        input  redirect, redirect_pc, halt,
        output halted, q_count, dbg_state
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata,
        input  out_valid, out_instr, out_pc,
        output out_ready,
        output redirect, redirect_pc, halt,
        input  halted, q_count, dbg_state
    );
endinterface

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch
//   Instruction fetch stage with a DEPTH-entry prefetch queue. Issues reads
//   to a one-cycle-latency instruction ROM, queues the returned words with
//   their PCs and hands them to decode over a valid/ready handshake.
//   A redirect flushes the queue, drops the in-flight word and restarts
//   fetch at redirect_pc. A halt stops issue for good (until rst) while
//   the queue keeps draining.
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset
//     bus   ifetch_prefetch_if.master (ROM port, decode handshake,
//           redirect/halt control, status and debug state)
module ifetch_prefetch #(
    parameter int              PC_W     = 10,
    parameter int              INSTR_W  = 10,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    ifetch_prefetch_if.master   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] OCC_LIMIT = (CNT_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_FULL   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_halted;
    logic [PC_W-1:0]    r_fetch_pc;
    logic               r_inflight;
    logic [PC_W-1:0]    r_inflight_pc;
    logic [INSTR_W-1:0] r_mem_instr [DEPTH];
    logic [PC_W-1:0]    r_mem_pc    [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_out_valid;
    logic [CNT_W:0]     w_occ;
    logic               w_space;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_count_next;
    logic [CNT_W:0]     w_occ_next;
    logic               w_space_next;

    assign w_out_valid = (r_count != '0);

    // Occupancy counts the in-flight word as already queued; a pop in the
    // same cycle does not free space until the next cycle.
    assign w_occ   = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_space = (w_occ < OCC_LIMIT);

    assign w_issue = (r_state == S_FETCH) && w_space && !bus.redirect && !bus.halt;
    assign w_push  = r_inflight && !bus.redirect;
    assign w_pop   = w_out_valid && bus.out_ready && !bus.redirect;

    always_comb begin
        w_count_next = r_count;
        if (bus.redirect) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    // The FSM moves on next-cycle occupancy so that FETCH always means
    // "space available now" and no issue slot is lost after a stall.
    assign w_occ_next   = {1'b0, w_count_next} + {{CNT_W{1'b0}}, w_issue};
    assign w_space_next = (w_occ_next < OCC_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                S_HALTED: r_state <= S_HALTED;
                default: begin
                    if (bus.halt) begin
                        r_state <= S_HALTED;
                    end else if (w_space_next) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_FULL;
                    end
                end
            endcase
            if (bus.halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else begin
            r_count    <= w_count_next;
            r_inflight <= w_issue;
            if (bus.redirect) begin
                r_fetch_pc <= bus.redirect_pc;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_issue) begin
                    r_fetch_pc    <= r_fetch_pc + PC_W'(1);
                    r_inflight_pc <= r_fetch_pc;
                end
                if (w_push) begin
                    r_mem_instr[r_wr_ptr] <= bus.imem_rdata;
                    r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
                    r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // rst gates only the output strobe so the ROM sees no read while in
    // reset; internal issue logic stays free of the reset net.
    assign bus.imem_req  = w_issue && !rst;
    assign bus.imem_addr = r_fetch_pc;
    assign bus.out_valid = w_out_valid;
    assign bus.out_instr = r_mem_instr[r_rd_ptr];
    assign bus.out_pc    = r_mem_pc[r_rd_ptr];
    assign bus.halted    = r_halted;
    assign bus.q_count   = r_count;
    assign bus.dbg_state = r_state;
endmodule
